// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - E/M/W hazard, forwarding and flush controller for the 5-stage core.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush performance counters.
module hazard_scoreboard #(
    parameter int REG_W   = 4,
    parameter int NUM_SRC = 3,
    parameter int PC_REG  = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_valid,
    input  logic [NUM_SRC*REG_W-1:0] dec_src,
    input  logic [NUM_SRC-1:0]       dec_src_used,
    input  logic [REG_W-1:0]         dec_dst,
    input  logic                     dec_reg_write,
    input  logic                     dec_mem_read,
    input  logic                     ex_branch_taken,
    output logic                     stall_f,
    output logic                     stall_d,
    output logic                     flush_d,
    output logic                     flush_e,
    output logic [2*NUM_SRC-1:0]     fwd_sel,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]              perf_stall_cnt,
    output logic [31:0]              perf_flush_cnt,
`endif
    output logic                     busy_pc
);

    localparam logic [REG_W-1:0] LP_PC = REG_W'(PC_REG);

    logic                     r_e_valid, r_e_reg_write, r_e_mem_read;
    logic [REG_W-1:0]         r_e_dst;
    logic [NUM_SRC*REG_W-1:0] r_e_src;
    logic [NUM_SRC-1:0]       r_e_src_used;
    logic                     r_m_valid, r_m_reg_write, r_m_mem_read;
    logic [REG_W-1:0]         r_m_dst;
    logic                     r_w_valid, r_w_reg_write;
    logic [REG_W-1:0]         r_w_dst;

    logic                     w_load_use;
    logic                     w_busy_pc;
    logic                     w_stall_f, w_stall_d, w_flush_d, w_flush_e;
    logic [2*NUM_SRC-1:0]     w_fwd_sel;
    logic [REG_W-1:0]         w_src;

    always_comb begin
        w_load_use = 1'b0;
        w_fwd_sel  = '0;
        w_src      = '0;
        w_busy_pc  = (r_e_valid && r_e_reg_write && r_e_dst == LP_PC) ||
                     (r_m_valid && r_m_reg_write && r_m_dst == LP_PC) ||
                     (r_w_valid && r_w_reg_write && r_w_dst == LP_PC);
        for (int i = 0; i < NUM_SRC; i++) begin
            w_src = dec_src[i*REG_W +: REG_W];
            if (dec_valid && dec_src_used[i] && w_src != LP_PC &&
                r_e_valid && r_e_mem_read && r_e_reg_write && w_src == r_e_dst)
                w_load_use = 1'b1;
        end
        // A matching load in M leaves the operand on the regfile path; the load-use stall keeps it unreachable.
        for (int i = 0; i < NUM_SRC; i++) begin
            w_src = r_e_src[i*REG_W +: REG_W];
            if (rst && r_e_valid && r_e_src_used[i] && w_src != LP_PC) begin
                if (r_m_valid && r_m_reg_write && r_m_dst == w_src)
                    w_fwd_sel[2*i +: 2] = r_m_mem_read ? 2'b00 : 2'b10;
                else if (r_w_valid && r_w_reg_write && r_w_dst == w_src)
                    w_fwd_sel[2*i +: 2] = 2'b01;
            end
        end
    end

    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        if (!rst) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (ex_branch_taken) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else begin
            w_stall_f = w_load_use || w_busy_pc;
            w_stall_d = w_load_use;
            w_flush_e = w_load_use;
            w_flush_d = w_busy_pc;
        end
    end

    assign stall_f = w_stall_f;
    assign stall_d = w_stall_d;
    assign flush_d = w_flush_d;
    assign flush_e = w_flush_e;
    assign fwd_sel = w_fwd_sel;
    assign busy_pc = rst && w_busy_pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_e_valid <= 1'b0;
            r_m_valid <= 1'b0;
            r_w_valid <= 1'b0;
        end else begin
            r_w_valid     <= r_m_valid;
            r_w_dst       <= r_m_dst;
            r_w_reg_write <= r_m_reg_write;
            r_m_valid     <= r_e_valid;
            r_m_dst       <= r_e_dst;
            r_m_reg_write <= r_e_reg_write;
            r_m_mem_read  <= r_e_mem_read;
            r_e_valid     <= dec_valid && !w_flush_e;
            r_e_dst       <= dec_dst;
            r_e_reg_write <= dec_reg_write;
            r_e_mem_read  <= dec_mem_read;
            r_e_src       <= dec_src;
            r_e_src_used  <= dec_src_used;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_f && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if ((w_flush_d || w_flush_e) && r_flush_cnt != 32'hFFFF_FFFF)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard-driven bench for hazard_scoreboard.
module tb_hazard_scoreboard;

    localparam int REG_W   = 4;
    localparam int NUM_SRC = 3;

    // Expected vector layout: {stall_f, stall_d, flush_d, flush_e, busy_pc, fwd_sel[5:0]}
    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_LU   = 5'b11010;
    localparam logic [4:0] C_BUSY = 5'b10101;
    localparam logic [4:0] C_FL   = 5'b00110;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     dec_valid = 1'b0;
    logic [NUM_SRC*REG_W-1:0] dec_src = '0;
    logic [NUM_SRC-1:0]       dec_src_used = '0;
    logic [REG_W-1:0]         dec_dst = '0;
    logic                     dec_reg_write = 1'b0;
    logic                     dec_mem_read = 1'b0;
    logic                     ex_branch_taken = 1'b0;
    logic                     stall_f, stall_d, flush_d, flush_e, busy_pc;
    logic [2*NUM_SRC-1:0]     fwd_sel;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]              perf_stall_cnt, perf_flush_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        r;
        logic        dv;
        logic [11:0] src;
        logic [2:0]  used;
        logic [3:0]  dst;
        logic        rw;
        logic        mr;
        logic        br;
        logic [10:0] e;
    } stim_t;

    logic [10:0] sb_q[$];
    logic [10:0] exp_v;
    logic [10:0] obs;

    hazard_scoreboard #(.REG_W(REG_W), .NUM_SRC(NUM_SRC), .PC_REG(15)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_src(dec_src),
        .dec_src_used(dec_src_used), .dec_dst(dec_dst), .dec_reg_write(dec_reg_write),
        .dec_mem_read(dec_mem_read), .ex_branch_taken(ex_branch_taken),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .fwd_sel(fwd_sel),
`ifdef HAZARD_PERF_CNT_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
        .busy_pc(busy_pc)
    );

    always #5 clk = ~clk;

    function automatic stim_t s(input logic r, input logic dv, input logic [3:0] s0, input logic [3:0] s1,
                                input logic [3:0] s2, input logic [2:0] u, input logic [3:0] d,
                                input logic rw, input logic mr, input logic br, input logic [10:0] e);
        stim_t t;
        t.r = r; t.dv = dv; t.src = {s2, s1, s0}; t.used = u; t.dst = d;
        t.rw = rw; t.mr = mr; t.br = br; t.e = e;
        return t;
    endfunction

    task automatic apply(input stim_t t);
        rst = t.r; dec_valid = t.dv; dec_src = t.src; dec_src_used = t.used;
        dec_dst = t.dst; dec_reg_write = t.rw; dec_mem_read = t.mr; ex_branch_taken = t.br;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            apply(s(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
        end
    endtask

    task automatic test_reset();
        stim_t t[$];
        t.push_back(s(0, 1, 3, 0, 0, 3'b001, 3, 1, 1, 0, {C_FL, 6'b0}));
        t.push_back(s(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, {C_NONE, 6'b0}));
        foreach (t[k]) begin
            @(posedge clk); #1;
            apply(t[k]); sb_q.push_back(t[k].e);
            @(negedge clk);
            exp_v = sb_q.pop_front();
            obs = {stall_f, stall_d, flush_d, flush_e, busy_pc, fwd_sel};
            n_total++;
            if (obs !== exp_v) $display("FAIL reset[%0d]: got %b expected %b", k, obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t t[$];
        idle(4);
        t.push_back(s(1, 1, 0, 0, 0, 3'b000, 3, 1, 0, 0, {C_NONE, 6'b000000}));
        t.push_back(s(1, 1, 3, 0, 0, 3'b001, 4, 1, 0, 0, {C_NONE, 6'b000000}));
        t.push_back(s(1, 1, 0, 3, 0, 3'b010, 5, 1, 0, 0, {C_NONE, 6'b000010}));
        t.push_back(s(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, {C_NONE, 6'b000100}));
        t.push_back(s(1, 1, 0, 0, 0, 3'b000, 6, 1, 0, 0, {C_NONE, 6'b000000}));
        t.push_back(s(1, 1, 0, 0, 0, 3'b000, 6, 1, 0, 0, {C_NONE, 6'b000000}));
        t.push_back(s(1, 1, 0, 0, 6, 3'b100, 7, 1, 0, 0, {C_NONE, 6'b000000}));
        t.push_back(s(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, {C_NONE, 6'b100000}));
        foreach (t[k]) begin
            @(posedge clk); #1;
            apply(t[k]); sb_q.push_back(t[k].e);
            @(negedge clk);
            exp_v = sb_q.pop_front();
            obs = {stall_f, stall_d, flush_d, flush_e, busy_pc, fwd_sel};
            n_total++;
            if (obs !== exp_v) $display("FAIL back_to_back[%0d]: got %b expected %b", k, obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        stim_t t[$];
        idle(4);
        t.push_back(s(1, 1, 0, 0, 0, 3'b000, 2, 1, 1, 0, {C_NONE, 6'b000000}));
        t.push_back(s(1, 1, 2, 0, 0, 3'b001, 7, 1, 0, 0, {C_LU,   6'b000000}));
        t.push_back(s(1, 1, 2, 0, 0, 3'b001, 7, 1, 0, 0, {C_NONE, 6'b000000}));
        t.push_back(s(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, {C_NONE, 6'b000001}));
        t.push_back(s(1, 1, 0, 0, 0, 3'b000, 2, 1, 1, 0, {C_NONE, 6'b000000}));
        t.push_back(s(1, 0, 2, 0, 0, 3'b001, 7, 1, 0, 0, {C_NONE, 6'b000000}));
        foreach (t[k]) begin
            @(posedge clk); #1;
            apply(t[k]); sb_q.push_back(t[k].e);
            @(negedge clk);
            exp_v = sb_q.pop_front();
            obs = {stall_f, stall_d, flush_d, flush_e, busy_pc, fwd_sel};
            n_total++;
            if (obs !== exp_v) $display("FAIL load_use[%0d]: got %b expected %b", k, obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_pc_write();
        stim_t t[$];
        idle(4);
        t.push_back(s(1, 1, 0, 0, 0, 3'b000, 15, 1, 0, 0, {C_NONE, 6'b0}));
        t.push_back(s(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, {C_BUSY, 6'b0}));
        t.push_back(s(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, {C_BUSY, 6'b0}));
        t.push_back(s(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, {C_BUSY, 6'b0}));
        t.push_back(s(1, 1, 0, 0, 0, 3'b000, 15, 0, 0, 0, {C_NONE, 6'b0}));
        t.push_back(s(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, {C_NONE, 6'b0}));
        foreach (t[k]) begin
            @(posedge clk); #1;
            apply(t[k]); sb_q.push_back(t[k].e);
            @(negedge clk);
            exp_v = sb_q.pop_front();
            obs = {stall_f, stall_d, flush_d, flush_e, busy_pc, fwd_sel};
            n_total++;
            if (obs !== exp_v) $display("FAIL pc_write[%0d]: got %b expected %b", k, obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_branch_load_use();
        stim_t t[$];
        idle(4);
        t.push_back(s(1, 1, 0, 0, 0, 3'b000, 2, 1, 1, 0, {C_NONE, 6'b0}));
        t.push_back(s(1, 1, 0, 2, 0, 3'b010, 9, 1, 0, 1, {C_FL,   6'b0}));
        t.push_back(s(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, {C_NONE, 6'b0}));
        foreach (t[k]) begin
            @(posedge clk); #1;
            apply(t[k]); sb_q.push_back(t[k].e);
            @(negedge clk);
            exp_v = sb_q.pop_front();
            obs = {stall_f, stall_d, flush_d, flush_e, busy_pc, fwd_sel};
            n_total++;
            if (obs !== exp_v) $display("FAIL branch_load_use[%0d]: got %b expected %b", k, obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_pc();
        stim_t t[$];
        idle(4);
        t.push_back(s(1, 1, 0, 0, 0, 3'b000, 15, 1, 0, 0, {C_NONE, 6'b0}));
        t.push_back(s(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, {C_BUSY, 6'b0}));
        t.push_back(s(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, {C_FL,   6'b0}));
        t.push_back(s(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, {C_NONE, 6'b0}));
        foreach (t[k]) begin
            @(posedge clk); #1;
            apply(t[k]); sb_q.push_back(t[k].e);
            @(negedge clk);
            exp_v = sb_q.pop_front();
            obs = {stall_f, stall_d, flush_d, flush_e, busy_pc, fwd_sel};
            n_total++;
            if (obs !== exp_v) $display("FAIL reset_mid_pc[%0d]: got %b expected %b", k, obs, exp_v);
            else n_pass++;
        end
`ifdef HAZARD_PERF_CNT_EN
        n_total++;
        if ({perf_stall_cnt, perf_flush_cnt} !== 64'd0)
            $display("FAIL perf_cnt_reset: got %0d/%0d expected 0/0", perf_stall_cnt, perf_flush_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_pc_src();
        stim_t t[$];
        idle(4);
        t.push_back(s(1, 1, 0, 0, 0, 3'b000, 15, 1, 0, 0, {C_NONE, 6'b0}));
        t.push_back(s(1, 1, 15, 0, 0, 3'b001, 8, 1, 0, 0, {C_BUSY, 6'b0}));
        t.push_back(s(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, {C_BUSY, 6'b0}));
        t.push_back(s(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, {C_BUSY, 6'b0}));
        t.push_back(s(1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, {C_NONE, 6'b0}));
        foreach (t[k]) begin
            @(posedge clk); #1;
            apply(t[k]); sb_q.push_back(t[k].e);
            @(negedge clk);
            exp_v = sb_q.pop_front();
            obs = {stall_f, stall_d, flush_d, flush_e, busy_pc, fwd_sel};
            n_total++;
            if (obs !== exp_v) $display("FAIL pc_src[%0d]: got %b expected %b", k, obs, exp_v);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_pc_write();
        test_branch_load_use();
        test_reset_mid_pc();
        test_pc_src();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
